// File: rtl/uvmt_mem_st_mem_arb_if.sv
// Bundle of requester A/B handshakes and the shared memory command/return bus.
// The arbiter connects through the slave modport. The requesters and memory side connect through the master modport.
interface uvmt_mem_st_mem_arb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    a_req;
    logic                    a_gnt;
    logic                    a_we;
    logic [ADDR_WIDTH-1:0]   a_addr;
    logic [DATA_WIDTH-1:0]   a_wdata;
    logic [DATA_WIDTH/8-1:0] a_be;
    logic                    a_rvalid;
    logic [DATA_WIDTH-1:0]   a_rdata;

    logic                    b_req;
    logic                    b_gnt;
    logic                    b_we;
    logic [ADDR_WIDTH-1:0]   b_addr;
    logic [DATA_WIDTH-1:0]   b_wdata;
    logic [DATA_WIDTH/8-1:0] b_be;
    logic                    b_rvalid;
    logic [DATA_WIDTH-1:0]   b_rdata;

    logic                    mem_req;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH/8-1:0] mem_be;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    modport master (
        output a_req, a_we, a_addr, a_wdata, a_be,
        output b_req, b_we, b_addr, b_wdata, b_be,
        output mem_rdata,
        input  a_gnt, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata, a_be,
        input  b_req, b_we, b_addr, b_wdata, b_be,
        input  mem_rdata,
        output a_gnt, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/uvmt_mem_st_mem_arb.sv
// Round-robin two-requester arbiter in front of a single-port memory, with in-order read return routing.
// Define UVMT_MEM_ST_MEM_ARB_STATS_EN to add the saturating per-port grant counters a_gnt_cnt / b_gnt_cnt.
module uvmt_mem_st_mem_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    uvmt_mem_st_mem_arb_if.slave bus
`ifdef UVMT_MEM_ST_MEM_ARB_STATS_EN
    ,
    output logic [15:0]          a_gnt_cnt,
    output logic [15:0]          b_gnt_cnt
`endif
);

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_e;

    owner_e last_grant_q, last_grant_d;
    logic   a_gnt, b_gnt;

    // Return pipeline. Index 0 takes the push. Index RD_LATENCY-1 lines up with mem_rdata.
    // The port bit is 1 for B.
    logic [RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
    logic [RD_LATENCY-1:0] port_pipe_q, port_pipe_d;
    logic                  ret_vld, ret_port;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant_q <= OWNER_B;
            vld_pipe_q   <= '0;
            port_pipe_q  <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            vld_pipe_q   <= vld_pipe_d;
            port_pipe_q  <= port_pipe_d;
        end
    end

    // On a tie the grant goes to the port that did not win last time.
    always_comb begin
        a_gnt        = 1'b0;
        b_gnt        = 1'b0;
        last_grant_d = last_grant_q;
        if (bus.a_req && (!bus.b_req || last_grant_q == OWNER_B)) begin
            a_gnt = 1'b1;
        end else if (bus.b_req) begin
            b_gnt = 1'b1;
        end
        if (a_gnt) begin
            last_grant_d = OWNER_A;
        end else if (b_gnt) begin
            last_grant_d = OWNER_B;
        end
    end

    always_comb begin
        bus.mem_req   = a_gnt | b_gnt;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_be    = '0;
        if (a_gnt) begin
            bus.mem_we    = bus.a_we;
            bus.mem_addr  = bus.a_addr;
            bus.mem_wdata = bus.a_wdata;
            bus.mem_be    = bus.a_be;
        end else if (b_gnt) begin
            bus.mem_we    = bus.b_we;
            bus.mem_addr  = bus.b_addr;
            bus.mem_wdata = bus.b_wdata;
            bus.mem_be    = bus.b_be;
        end
    end

    always_comb begin
        vld_pipe_d     = '0;
        port_pipe_d    = '0;
        vld_pipe_d[0]  = (a_gnt & ~bus.a_we) | (b_gnt & ~bus.b_we);
        port_pipe_d[0] = b_gnt;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            port_pipe_d[i] = port_pipe_q[i-1];
        end
    end

    assign ret_vld      = vld_pipe_q[RD_LATENCY-1];
    assign ret_port     = port_pipe_q[RD_LATENCY-1];

    assign bus.a_gnt    = a_gnt;
    assign bus.b_gnt    = b_gnt;
    assign bus.a_rvalid = ret_vld & ~ret_port;
    assign bus.b_rvalid = ret_vld &  ret_port;
    assign bus.a_rdata  = (ret_vld && !ret_port) ? bus.mem_rdata : '0;
    assign bus.b_rdata  = (ret_vld &&  ret_port) ? bus.mem_rdata : '0;

`ifdef UVMT_MEM_ST_MEM_ARB_STATS_EN
    logic [15:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_cnt_q <= '0;
            b_cnt_q <= '0;
        end else begin
            a_cnt_q <= a_cnt_d;
            b_cnt_q <= b_cnt_d;
        end
    end

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        a_cnt_d = a_cnt_q;
        b_cnt_d = b_cnt_q;
        if (a_gnt && a_cnt_q != 16'hFFFF) a_cnt_d = a_cnt_q + 16'd1;
        if (b_gnt && b_cnt_q != 16'hFFFF) b_cnt_d = b_cnt_q + 16'd1;
    end

    assign a_gnt_cnt = a_cnt_q;
    assign b_gnt_cnt = b_cnt_q;
`endif

endmodule
